// File: rtl/serv_rf_sched.sv
// Shares the bit-serial register file between the core datapath and a 32-bit debug port.
// Define SERV_RF_SCHED_RR_EN for round-robin arbitration; otherwise debug has fixed priority.
module serv_rf_sched (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_c_req,
   input  logic [4:0]  i_c_rs1_addr,
   input  logic [4:0]  i_c_rs2_addr,
   input  logic [4:0]  i_c_rd_addr,
   input  logic        i_c_wen,
   input  logic        i_c_rd,
   output logic        o_c_gnt,
   output logic        o_c_en,
   output logic        o_c_rs1,
   output logic        o_c_rs2,
   output logic        o_c_done,
   input  logic        i_d_req,
   input  logic [4:0]  i_d_rs1_addr,
   input  logic [4:0]  i_d_rd_addr,
   input  logic        i_d_wen,
   input  logic [31:0] i_d_wdata,
   output logic        o_d_gnt,
   output logic        o_d_done,
   output logic [31:0] o_d_rdata,
   output logic        o_rf_go,
   input  logic        i_rf_ready,
   output logic        o_rf_rd_en,
   output logic        o_rf_rd,
   output logic [4:0]  o_rf_rd_addr,
   output logic [4:0]  o_rf_rs1_addr,
   output logic [4:0]  o_rf_rs2_addr,
   input  logic        i_rf_rs1,
   input  logic        i_rf_rs2,
   output logic        o_busy
);

   typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

   state_t      state_reg, state_next;
   logic [4:0]  cnt_reg;
   logic        owner_reg;   // 1: debug port owns the current access
   logic        wen_reg;
   logic        go_reg;
   logic [31:0] shift_reg;
   logic [31:0] rdata_reg;
   logic [4:0]  rs1_reg, rs2_reg, rd_reg;
   logic        take;
   logic        pick_dbg;
   logic        xfer;

`ifdef SERV_RF_SCHED_RR_EN
   logic        last_reg;    // 1: debug was granted last
   assign pick_dbg = i_d_req & (~i_c_req | ~last_reg);
`else
   assign pick_dbg = i_d_req;
`endif

   assign take = i_c_req | i_d_req;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      xfer       = 1'b0;
      o_busy     = 1'b1;
      o_c_done   = 1'b0;
      o_d_done   = 1'b0;
      case (state_reg)
         IDLE: begin
            o_busy = 1'b0;
            if (take) state_next = WAIT;
         end
         WAIT: if (i_rf_ready) state_next = XFER;
         XFER: begin
            xfer = 1'b1;
            if (cnt_reg == 5'd31) state_next = DONE;
         end
         DONE: begin
            o_c_done   = ~owner_reg;
            o_d_done   = owner_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      o_c_en     = xfer & ~owner_reg;
      o_c_rs1    = o_c_en & i_rf_rs1;
      o_c_rs2    = o_c_en & i_rf_rs2;
      o_rf_rd_en = xfer & wen_reg;
      o_rf_rd    = xfer & (owner_reg ? shift_reg[0] : i_c_rd);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_reg   <= 5'd0;
         owner_reg <= 1'b0;
         wen_reg   <= 1'b0;
         go_reg    <= 1'b0;
         shift_reg <= 32'd0;
         rdata_reg <= 32'd0;
         rs1_reg   <= 5'd0;
         rs2_reg   <= 5'd0;
         rd_reg    <= 5'd0;
`ifdef SERV_RF_SCHED_RR_EN
         last_reg  <= 1'b1;
`endif
      end else begin
         go_reg <= 1'b0;
         if (state_reg == IDLE && take) begin
            go_reg    <= 1'b1;
            owner_reg <= pick_dbg;
            wen_reg   <= pick_dbg ? i_d_wen : i_c_wen;
            rs1_reg   <= pick_dbg ? i_d_rs1_addr : i_c_rs1_addr;
            rs2_reg   <= pick_dbg ? 5'd0 : i_c_rs2_addr;
            rd_reg    <= pick_dbg ? i_d_rd_addr : i_c_rd_addr;
            if (pick_dbg) shift_reg <= i_d_wdata;
`ifdef SERV_RF_SCHED_RR_EN
            last_reg  <= pick_dbg;
`endif
         end
         if (state_reg == XFER) begin
            cnt_reg <= cnt_reg + 5'd1;
            if (owner_reg) begin
               shift_reg <= {1'b0, shift_reg[31:1]};
               rdata_reg <= {i_rf_rs1, rdata_reg[31:1]};
            end
         end
      end
   end

   // Grant and go come straight from the register set on the IDLE->WAIT edge.
   assign o_rf_go       = go_reg;
   assign o_c_gnt       = go_reg & ~owner_reg;
   assign o_d_gnt       = go_reg & owner_reg;
   assign o_d_rdata     = rdata_reg;
   assign o_rf_rs1_addr = rs1_reg;
   assign o_rf_rs2_addr = rs2_reg;
   assign o_rf_rd_addr  = rd_reg;

endmodule

// File: tb/tb_serv_rf_sched.sv
// Bench for serv_rf_sched: a behavioural bit-serial regfile plus a word-level reference model.
`timescale 1ns/1ps
module tb_serv_rf_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        c_req, c_wen, c_rd;
   logic [4:0]  c_rs1_addr, c_rs2_addr, c_rd_addr;
   logic        c_gnt, c_en, c_rs1, c_rs2, c_done;
   logic        d_req, d_wen;
   logic [4:0]  d_rs1_addr, d_rd_addr;
   logic [31:0] d_wdata, d_rdata;
   logic        d_gnt, d_done;
   logic        rf_go, rf_ready, rf_rd_en, rf_rd, rf_rs1, rf_rs2, busy;
   logic [4:0]  rf_rd_addr, rf_rs1_addr, rf_rs2_addr;

   serv_rf_sched dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_c_req(c_req), .i_c_rs1_addr(c_rs1_addr), .i_c_rs2_addr(c_rs2_addr),
      .i_c_rd_addr(c_rd_addr), .i_c_wen(c_wen), .i_c_rd(c_rd),
      .o_c_gnt(c_gnt), .o_c_en(c_en), .o_c_rs1(c_rs1), .o_c_rs2(c_rs2), .o_c_done(c_done),
      .i_d_req(d_req), .i_d_rs1_addr(d_rs1_addr), .i_d_rd_addr(d_rd_addr),
      .i_d_wen(d_wen), .i_d_wdata(d_wdata),
      .o_d_gnt(d_gnt), .o_d_done(d_done), .o_d_rdata(d_rdata),
      .o_rf_go(rf_go), .i_rf_ready(rf_ready), .o_rf_rd_en(rf_rd_en), .o_rf_rd(rf_rd),
      .o_rf_rd_addr(rf_rd_addr), .o_rf_rs1_addr(rf_rs1_addr), .o_rf_rs2_addr(rf_rs2_addr),
      .i_rf_rs1(rf_rs1), .i_rf_rs2(rf_rs2), .o_busy(busy)
   );

   typedef struct {
      bit          dbg;
      logic [4:0]  rs1, rs2, rd;
      bit          wen;
      logic [31:0] wdata;
      int          rdy;
      logic [31:0] exp_rs1, exp_rs2;
   } txn_t;

   // Environment state: regfile contents, serial capture buffers, event log.
   logic [31:0] rf_mem [32];
   logic [31:0] ref_mem [32];
   logic [31:0] wbuf, crs1_buf, crs2_buf, c_wdata, d_rdata_done;
   int cyc, rdy_dly, rdy_cnt, bidx, rden_cnt, cen_cnt, stray;
   int c_gnts, d_gnts, c_dones, d_dones;
   int c_gnt_cyc, d_gnt_cyc, c_done_cyc, d_done_cyc, last_done_cyc;
   bit waiting, pending;
   bit model_last;   // 1: debug granted last
   int n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   function automatic logic [25:0] out_bits();
      return {c_gnt, c_en, c_rs1, c_rs2, c_done, d_gnt, d_done, rf_go, rf_rd_en, rf_rd, busy,
              rf_rd_addr, rf_rs1_addr, rf_rs2_addr};
   endfunction

   // Regfile + core serial side, evaluated half a cycle away from the active edge.
   initial begin
      cyc = 0; bidx = -1; waiting = 0; pending = 0; stray = 0; rdy_cnt = 0;
      c_gnts = 0; d_gnts = 0; c_dones = 0; d_dones = 0; rden_cnt = 0; cen_cnt = 0;
      c_gnt_cyc = 0; d_gnt_cyc = 0; c_done_cyc = 0; d_done_cyc = 0; last_done_cyc = 0;
      rf_ready = 0; rf_rs1 = 0; rf_rs2 = 0; c_rd = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            bidx = -1; waiting = 0; pending = 0;
            rf_ready = 0; rf_rs1 = 0; rf_rs2 = 0; c_rd = 0;
            continue;
         end
         if (pending) begin bidx = 0; pending = 0; rden_cnt = 0; cen_cnt = 0; end
         if (bidx >= 0) begin
            rf_rs1 = rf_mem[rf_rs1_addr][bidx];
            rf_rs2 = rf_mem[rf_rs2_addr][bidx];
            c_rd   = c_wdata[bidx];
         end else begin
            rf_rs1 = 1'($urandom); rf_rs2 = 1'($urandom); c_rd = 1'($urandom);
         end
         rf_ready = 0;
         if (rf_go) begin rdy_cnt = rdy_dly; waiting = 1; end
         else if (waiting) rdy_cnt--;
         if (waiting && rdy_cnt == 0) begin rf_ready = 1; waiting = 0; pending = 1; end
         #1;
         if (bidx >= 0) begin
            if (rf_rd_en) begin wbuf[bidx] = rf_rd; rden_cnt++; end
            if (c_en) begin cen_cnt++; crs1_buf[bidx] = c_rs1; crs2_buf[bidx] = c_rs2; end
            bidx++;
            if (bidx == 32) begin
               if (rden_cnt == 32 && rf_rd_addr != 5'd0) rf_mem[rf_rd_addr] = wbuf;
               bidx = -1;
            end
         end else if (c_en | rf_rd_en | c_rs1 | c_rs2 | rf_rd) stray++;
         if ((rf_go != (c_gnt | d_gnt)) || (c_gnt && d_gnt)) stray++;
         if (c_gnt)  begin c_gnts++; c_gnt_cyc = cyc; end
         if (d_gnt)  begin d_gnts++; d_gnt_cyc = cyc; end
         if (c_done) begin c_dones++; c_done_cyc = cyc; last_done_cyc = cyc; end
         if (d_done) begin d_dones++; d_done_cyc = cyc; last_done_cyc = cyc; d_rdata_done = d_rdata; end
      end
   end

   task automatic do_txn(input int id, input txn_t t);
      int c0, n, g0, dn0, gcyc;
      g0  = t.dbg ? d_gnts : c_gnts;
      dn0 = t.dbg ? d_dones : c_dones;
      rdy_dly = t.rdy;
      if (t.dbg) begin
         d_rs1_addr = t.rs1; d_rd_addr = t.rd; d_wen = t.wen; d_wdata = t.wdata; d_req = 1;
      end else begin
         c_rs1_addr = t.rs1; c_rs2_addr = t.rs2; c_rd_addr = t.rd; c_wen = t.wen;
         c_wdata = t.wdata; c_req = 1;
      end
      c0 = cyc;
      n = 0;
      while ((t.dbg ? d_gnts : c_gnts) == g0 && n < 10) begin step(); n++; end
      c_req = 0; d_req = 0;
      gcyc = t.dbg ? d_gnt_cyc : c_gnt_cyc;
      chk($sformatf("txn%0d gnt_latency", id), gcyc - c0, 1);
      chk($sformatf("txn%0d latched_addr", id), 32'({rf_rs1_addr, rf_rs2_addr, rf_rd_addr}),
          32'({t.rs1, (t.dbg ? 5'd0 : t.rs2), t.rd}));
      n = 0;
      while ((t.dbg ? d_dones : c_dones) == dn0 && n < 300) begin step(); n++; end
      chk($sformatf("txn%0d done_cycle", id), (t.dbg ? d_done_cyc : c_done_cyc) - gcyc, t.rdy + 35 - 2);
      chk($sformatf("txn%0d rd_en_cycles", id), rden_cnt, t.wen ? 32 : 0);
      chk($sformatf("txn%0d c_en_cycles", id), cen_cnt, t.dbg ? 0 : 32);
      if (t.dbg) chk($sformatf("txn%0d d_rdata", id), d_rdata_done, t.exp_rs1);
      else begin
         chk($sformatf("txn%0d c_rs1", id), crs1_buf, t.exp_rs1);
         chk($sformatf("txn%0d c_rs2", id), crs2_buf, t.exp_rs2);
      end
      if (t.wen && t.rd != 5'd0) ref_mem[t.rd] = t.wdata;
      model_last = t.dbg;
      if (t.wen) chk($sformatf("txn%0d rf_write", id), rf_mem[t.rd], ref_mem[t.rd]);
      step();
      chk($sformatf("txn%0d idle_after_done", id), 32'(busy), 0);
      chk($sformatf("txn%0d single_pulses", id),
          (t.dbg ? d_gnts - g0 + d_dones - dn0 : c_gnts - g0 + c_dones - dn0), 2);
      $display("txn %0d: %s rs1=%0d rs2=%0d rd=%0d wen=%0d wdata=%08h rdy=%0d", id,
               t.dbg ? "debug" : "core ", t.rs1, t.rs2, t.rd, t.wen, t.wdata, t.rdy);
   endtask

   txn_t vec [7];
   txn_t rt;

   initial begin
      int n, won, exp_w, g_c, g_d, c0, dn, gc;
      logic [31:0] old11;
      for (int i = 0; i < 32; i++) begin rf_mem[i] = 32'd0; ref_mem[i] = 32'd0; end
      rf_mem[5] = 32'hA5A5_0F0F; ref_mem[5] = 32'hA5A5_0F0F;
      rf_mem[6] = 32'h1234_5678; ref_mem[6] = 32'h1234_5678;
      model_last = 1;
      rst_n = 0; c_req = 0; d_req = 0; c_wen = 0; d_wen = 0; rdy_dly = 2;
      c_rs1_addr = 0; c_rs2_addr = 0; c_rd_addr = 0; d_rs1_addr = 0; d_rd_addr = 0;
      d_wdata = 0; c_wdata = 0;

      vec[0] = '{1'b0, 5'd5, 5'd6, 5'd0, 1'b0, 32'h0,         2, 32'hA5A5_0F0F, 32'h1234_5678};
      vec[1] = '{1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 32'hDEAD_BEEF, 2, 32'h0,         32'h0};
      vec[2] = '{1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 32'h0,         2, 32'hDEAD_BEEF, 32'h0};
      vec[3] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 2, 32'h0,         32'h0};
      vec[4] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0,         3, 32'h0,         32'h0};
      vec[5] = '{1'b0, 5'd7, 5'd5, 5'd9, 1'b1, 32'h0F0F_1234, 0, 32'hDEAD_BEEF, 32'hA5A5_0F0F};
      vec[6] = '{1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 32'h0,         5, 32'h0F0F_1234, 32'h0};

      step(); step(); step();
      chk("reset outputs", 32'(out_bits()), 0);
      chk("reset d_rdata", d_rdata, 0);
      rst_n = 1;
      step();

      for (int i = 0; i < 7; i++) do_txn(i, vec[i]);

      for (int i = 0; i < 16; i++) begin
         rt.dbg = 1'($urandom); rt.rs1 = 5'($urandom_range(0, 31)); rt.rs2 = 5'($urandom_range(0, 31));
         rt.rd = 5'($urandom_range(0, 31)); rt.wen = 1'($urandom); rt.wdata = $urandom;
         rt.rdy = int'($urandom_range(0, 4));
         rt.exp_rs1 = ref_mem[rt.rs1];
         rt.exp_rs2 = rt.dbg ? 32'd0 : ref_mem[rt.rs2];
         do_txn(100 + i, rt);
      end

      // Both requesters held across three consecutive accesses.
      c_rs1_addr = 5; c_rs2_addr = 6; c_rd_addr = 0; c_wen = 0;
      d_rs1_addr = 7; d_rd_addr = 0; d_wen = 0; rdy_dly = 2;
      c_req = 1; d_req = 1; c0 = cyc;
      for (int k = 0; k < 3; k++) begin
`ifdef SERV_RF_SCHED_RR_EN
         exp_w = model_last ? 0 : 1;
`else
         exp_w = 1;
`endif
         g_c = c_gnts; g_d = d_gnts; n = 0;
         while (c_gnts == g_c && d_gnts == g_d && n < 100) begin step(); n++; end
         won = (d_gnts != g_d) ? 1 : (c_gnts != g_c) ? 0 : 2;
         gc = won == 1 ? d_gnt_cyc : c_gnt_cyc;
         chk($sformatf("tie%0d winner", k), won, exp_w);
         if (k == 0) chk("tie0 gnt_latency", gc - c0, 1);
         else chk($sformatf("tie%0d gap_after_done", k), gc - last_done_cyc, 2);
         model_last = exp_w[0];
         if (k == 2) begin c_req = 0; d_req = 0; end
         dn = c_dones + d_dones; n = 0;
         while (c_dones + d_dones == dn && n < 100) begin step(); n++; end
         $display("tie access %0d granted to %s", k, won == 1 ? "debug" : "core");
      end
      g_c = c_gnts; g_d = d_gnts;
      repeat (30) step();
      chk("tie no_extra_gnt", (c_gnts - g_c) + (d_gnts - g_d), 0);

      // Core request arrives during a debug write transfer.
      old11 = ref_mem[11];
      d_rs1_addr = 11; d_rd_addr = 11; d_wen = 1; d_wdata = 32'h1357_2468; rdy_dly = 1;
      g_d = d_gnts; d_req = 1; n = 0;
      while (d_gnts == g_d && n < 10) begin step(); n++; end
      d_req = 0;
      repeat (12) step();
      c_rs1_addr = 11; c_rs2_addr = 7; c_wen = 0; g_c = c_gnts; c_req = 1; n = 0;
      while (c_gnts == g_c && n < 100) begin step(); n++; end
      c_req = 0;
      chk("busy core_gnt_after_d_done", c_gnt_cyc - d_done_cyc, 2);
      chk("busy d_rdata_old", d_rdata_done, old11);
      ref_mem[11] = 32'h1357_2468;
      dn = c_dones; n = 0;
      while (c_dones == dn && n < 100) begin step(); n++; end
      chk("busy core_rs1", crs1_buf, ref_mem[11]);
      chk("busy core_rs2", crs2_buf, ref_mem[7]);
      model_last = 0;
      $display("busy-arrival sequence: debug write x11 then core read x11/x7");
      step();

      // A core request withdrawn while the scheduler is busy is never granted.
      d_rs1_addr = 7; d_wen = 0; rdy_dly = 3; g_d = d_gnts; d_req = 1; n = 0;
      while (d_gnts == g_d && n < 10) begin step(); n++; end
      d_req = 0; g_c = c_gnts;
      repeat (5) step();
      c_req = 1;
      repeat (3) step();
      c_req = 0;
      dn = d_dones; n = 0;
      while (d_dones == dn && n < 100) begin step(); n++; end
      chk("drop d_rdata", d_rdata_done, ref_mem[7]);
      repeat (10) step();
      chk("drop no_core_gnt", c_gnts - g_c, 0);
      model_last = 1;
      $display("dropped-request sequence: core request withdrawn during debug access");

      // Asynchronous reset at XFER bit 10 of a core write.
      c_rs1_addr = 5; c_rs2_addr = 6; c_rd_addr = 10; c_wen = 1; c_wdata = 32'h55AA_55AA;
      rdy_dly = 2; g_c = c_gnts; c_req = 1; n = 0;
      while (c_gnts == g_c && n < 10) begin step(); n++; end
      c_req = 0; gc = c_gnt_cyc; n = 0;
      while (cyc < gc + 13 && n < 50) begin step(); n++; end
      chk("rst in_xfer_before", 32'({c_en, rf_rd_en}), 32'h3);
      dn = c_dones;
      rst_n = 0;
      #1;
      chk("rst outputs_cleared", 32'(out_bits()), 0);
      chk("rst d_rdata_cleared", d_rdata, 0);
      step(); step(); step();
      rst_n = 1;
      model_last = 1;
      repeat (40) step();
      chk("rst no_done", c_dones - dn, 0);
      chk("rst no_write", rf_mem[10], ref_mem[10]);
      $display("reset sequence: core write aborted at bit 10");
      vec[0].exp_rs1 = ref_mem[5]; vec[0].exp_rs2 = ref_mem[6];
      do_txn(200, vec[0]);

      chk("stray outputs", stray, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/serv_rf_sched.md
# serv_rf_sched

Scheduler that shares the bit-serial register file between two requesters: the core's serial datapath and a 32-bit parallel debug port. It arbitrates and latches one access at a time, issues the regfile start pulse, waits for regfile ready, then runs a 32-cycle bit-serial read/write window. For the debug port it also serializes write data and deserializes rs1 read data. It sits between the core/debug module and the regfile instance.

## Interface
- No parameters; data width fixed at 32 bits (5-bit counter).
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous assert, active low
- i_c_req  in  1  core request, level; held until o_c_gnt
- i_c_rs1_addr, i_c_rs2_addr, i_c_rd_addr  in  5 each  core register addresses
- i_c_wen  in  1  core access writes rd
- i_c_rd  in  1  core serial write bit, LSB first
- o_c_gnt  out  1  one-cycle core grant pulse
- o_c_en  out  1  core bit window active
- o_c_rs1, o_c_rs2  out  1 each  serial read bits to core, 0 outside window
- o_c_done  out  1  one-cycle core completion pulse
- i_d_req  in  1  debug request, level; held until o_d_gnt
- i_d_rs1_addr, i_d_rd_addr  in  5 each  debug addresses
- i_d_wen  in  1  debug access writes rd
- i_d_wdata  in  32  debug write data, sampled at grant
- o_d_gnt, o_d_done  out  1 each  debug grant / completion pulses
- o_d_rdata  out  32  debug rs1 read value, valid from o_d_done until next debug grant
- o_rf_go  out  1  regfile start pulse
- i_rf_ready  in  1  regfile ready
- o_rf_rd_en, o_rf_rd  out  1 each  regfile write enable / serial write bit
- o_rf_rd_addr, o_rf_rs1_addr, o_rf_rs2_addr  out  5 each  latched addresses
- i_rf_rs1, i_rf_rs2  in  1 each  regfile serial read bits
- o_busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, WAIT, XFER, DONE.
- IDLE: if any request is active, arbitrate, latch the winner's addresses and wen (and i_d_wdata into the shift register for debug), record the owner, then go to WAIT. Otherwise stay in IDLE.
- WAIT: the first WAIT cycle drives o_rf_go=1 and the winner's gnt=1 for exactly one cycle. Stay in WAIT until i_rf_ready=1, then go to XFER.
- XFER: 32 cycles, bit counter 0..31. Bit k of rs1/rs2 is on i_rf_rs1/i_rf_rs2 in cycle k. On counter 31, go to DONE.
- DONE: one cycle. Owner's done=1, then go to IDLE.
- Write path: o_rf_rd_en equals latched wen for all 32 XFER cycles, and is 0 elsewhere. It is asserted even when rd_addr=0 so that the regfile write counter stays even-aligned; the regfile suppresses writes to x0.
- o_rf_rd source: core owner uses i_c_rd. Debug owner uses the shift register LSB, which shifts right each XFER cycle.
- Read path: core owner gets o_c_rs1/o_c_rs2 = i_rf_rs1/i_rf_rs2 with o_c_en=1. Debug owner shifts o_d_rdata <= {i_rf_rs1, o_d_rdata[31:1]} each XFER cycle. o_rf_rs2_addr = 0 for debug.
- Latched addresses on o_rf_* stay stable from the grant through DONE.
- Requests arriving while busy are held and are not granted until the next IDLE.
- A request that drops before IDLE samples it is never granted.

## Timing
- Reset values: all outputs 0, o_d_rdata=0, state IDLE, RR pointer = "debug last".
- A reset asserted mid-access aborts immediately and returns everything to reset values with no done pulse. The regfile is reset by the same reset.
- Request sampled in IDLE at cycle 0, with ready 2 cycles after go:
  - gnt and o_rf_go at cycle 1
  - ready at cycle 3
  - XFER cycles 4..35
  - done at cycle 36
  - earliest next grant at cycle 38
- WAIT length is unbounded; the scheduler follows i_rf_ready exactly.
- Go and gnt are registered. No combinational path from any requester input to any output, except the o_rf_rd / o_c_rs* pass-through during XFER.

## Configuration
- SERV_RF_SCHED_RR_EN defined: round-robin arbitration. On a tie, grant the requester not granted last. The pointer resets to "debug last", so the core wins the first tie.
- SERV_RF_SCHED_RR_EN undefined: fixed priority, debug always wins ties. The RR pointer is not implemented.

## Test plan
- Core read: i_c_req, rs1=5, rs2=6, wen=0, regfile x5=0xA5A5_0F0F, x6=0x1234_5678.
  - gnt and go at cycle 1; o_c_en for 32 cycles.
  - o_c_rs1/o_c_rs2 serialize both values LSB first.
  - o_rf_rd_en stays 0; o_c_done at cycle 36.
- Debug write then read: write x7=0xDEAD_BEEF, then read x7.
  - o_rf_rd_en held for 32 cycles during the write.
  - o_d_rdata=0xDEAD_BEEF at the second o_d_done.
- Debug write to x0 with 0xFFFF_FFFF:
  - rd_en still asserted for 32 cycles.
  - A later read of x0 returns 0.
- Simultaneous requests, held three times:
  - RR build grants core, debug, core.
  - Non-RR build grants debug every time and the core starves.
- Core request asserted during a debug XFER:
  - No gnt until after the debug DONE.
  - Core gnt 2 cycles after o_d_done.
- i_rst_n low at XFER cycle 10:
  - Outputs clear immediately; no done pulse.
  - After release, a new request completes normally.
